radix2_divider: RTL and testbench



---
 rtl/radix2_divider_pkg.sv | 4 +
 rtl/radix2_divider_if.sv | 22 ++
 rtl/radix2_divider_step.sv | 17 +
 rtl/radix2_divider.sv | 93 +++++++++
 tb/tb_radix2_divider.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/radix2_divider_pkg.sv
// radix2_divider_pkg: shared divider FSM state encoding.
package radix2_divider_pkg;
    typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_e;
endpackage

// File: rtl/radix2_divider_if.sv
// radix2_divider_if: start/ready/valid handshake between execute stage and divider.
interface radix2_divider_if #(parameter int SIZE = 33);
    logic            start;
    logic            ready;
    logic            valid;
    logic            error;
    logic            is_signed;
    logic            kill;
    logic [SIZE-1:0] dividend;
    logic [SIZE-1:0] divisor;
    logic [SIZE-1:0] quotient;
    logic [SIZE-1:0] remainder;

    modport master (
        output start, is_signed, kill, dividend, divisor,
        input  ready, valid, error, quotient, remainder
    );
    modport slave (
        input  start, is_signed, kill, dividend, divisor,
        output ready, valid, error, quotient, remainder
    );
endinterface

// File: rtl/radix2_divider_step.sv
// radix2_div_step: one restoring-division step producing a quotient bit and new partial remainder.
module radix2_div_step #(parameter int SIZE = 33) (
    input  logic [SIZE-1:0] rem,
    input  logic            bit_in,
    input  logic [SIZE-1:0] dvs,
    output logic [SIZE-1:0] rem_next,
    output logic            q_bit
);
    logic [SIZE:0] shifted;
    logic [SIZE:0] trial;

    // rem < dvs keeps shifted below 2*dvs, so the top trial bit is a true sign
    assign shifted  = {rem, bit_in};
    assign trial    = shifted - {1'b0, dvs};
    assign q_bit    = ~trial[SIZE];
    assign rem_next = q_bit ? trial[SIZE-1:0] : shifted[SIZE-1:0];
endmodule

// File: rtl/radix2_divider.sv
// radix2_divider: iterative radix-2 restoring divider with RISC-V M semantics.
module radix2_divider
    import radix2_divider_pkg::*;
#(
    parameter int SIZE = 33
) (
    input logic              clk,
    input logic              rst_n,
    radix2_divider_if.slave  bus
);
    localparam int CW = $clog2(SIZE);

    div_state_e      state;
    logic [CW-1:0]   cnt;
    logic [SIZE-1:0] rem, quo, dvs, rem_next, q_fin;
    logic            neg_q, neg_r, q_bit, accept;

    function automatic logic [SIZE-1:0] neg_if(input logic [SIZE-1:0] x, input logic n);
        return n ? -x : x;
    endfunction

    function automatic logic [SIZE-1:0] abs_v(input logic [SIZE-1:0] x, input logic s);
        return neg_if(x, s && x[SIZE-1]);
    endfunction

    assign accept = bus.start && bus.ready && !bus.kill;
    assign q_fin  = {quo[SIZE-2:0], q_bit};

    // quo starts as |dividend| and shifts its MSB into the step while collecting quotient bits
    radix2_div_step #(.SIZE(SIZE)) u_step (
        .rem      (rem),
        .bit_in   (quo[SIZE-1]),
        .dvs      (dvs),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= DIV_IDLE;
            cnt           <= '0;
            rem           <= '0;
            quo           <= '0;
            dvs           <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            bus.ready     <= 1'b1;
            bus.valid     <= 1'b0;
            bus.error     <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
        end else if (bus.kill) begin
            state     <= DIV_IDLE;
            bus.ready <= 1'b1;
            bus.valid <= 1'b0;
        end else if (accept) begin
            rem   <= '0;
            cnt   <= CW'(SIZE - 1);
            quo   <= abs_v(bus.dividend, bus.is_signed);
            dvs   <= abs_v(bus.divisor, bus.is_signed);
            neg_q <= bus.is_signed && (bus.dividend[SIZE-1] ^ bus.divisor[SIZE-1]);
            neg_r <= bus.is_signed && bus.dividend[SIZE-1];
            if (bus.divisor == '0) begin
                state         <= DIV_DONE;
                bus.ready     <= 1'b1;
                bus.valid     <= 1'b1;
                bus.error     <= 1'b1;
                bus.quotient  <= '1;
                bus.remainder <= bus.dividend;
            end else begin
                state     <= DIV_CALC;
                bus.ready <= 1'b0;
                bus.valid <= 1'b0;
            end
        end else if (state == DIV_CALC) begin
            rem <= rem_next;
            quo <= q_fin;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                state         <= DIV_DONE;
                bus.ready     <= 1'b1;
                bus.valid     <= 1'b1;
                bus.error     <= 1'b0;
                bus.quotient  <= neg_if(q_fin, neg_q);
                bus.remainder <= neg_if(rem_next, neg_r);
            end
        end else begin
            state     <= DIV_IDLE;
            bus.ready <= 1'b1;
            bus.valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_radix2_divider.sv
// tb_radix2_divider: directed vectors for the radix-2 divider at SIZE=33 and SIZE=32.
module tb_radix2_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    radix2_divider_if #(.SIZE(33)) b33();
    radix2_divider_if #(.SIZE(32)) b32();

    radix2_divider #(.SIZE(33)) dut (.clk(clk), .rst_n(rst_n), .bus(b33.slave));
    radix2_divider #(.SIZE(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));

    int errors = 0;
    int checks = 0;
    int lat;
    bit rdy_seen;

    localparam logic [32:0] ONES = 33'h1_FFFF_FFFF;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // drive at a negedge; accepted on the following posedge, then scramble inputs
    task automatic issue(input logic [32:0] a, input logic [32:0] b, input logic s);
        b33.start = 1'b1;
        b33.dividend = a;
        b33.divisor = b;
        b33.is_signed = s;
        @(posedge clk);
        #1;
        b33.start = 1'b0;
        b33.dividend = 33'h0_5A5A_5A5A;
        b33.divisor = '0;
        b33.is_signed = ~s;
    endtask

    task automatic wait_valid(input int base, output int l, output bit rs);
        l = -1;
        rs = 1'b0;
        for (int k = base + 1; k <= base + 80; k++) begin
            @(negedge clk);
            if (b33.valid) begin
                l = k;
                break;
            end
            if (b33.ready) rs = 1'b1;
        end
    endtask

    task automatic result(input string tag, input logic [32:0] q, input logic [32:0] r, input logic e);
        check({tag, ".q"}, 64'(b33.quotient), 64'(q));
        check({tag, ".r"}, 64'(b33.remainder), 64'(r));
        check({tag, ".err"}, 64'(b33.error), 64'(e));
    endtask

    initial begin
        b33.start = 0; b33.kill = 0; b33.is_signed = 0; b33.dividend = 0; b33.divisor = 0;
        b32.start = 0; b32.kill = 0; b32.is_signed = 0; b32.dividend = 0; b32.divisor = 0;
        repeat (2) @(negedge clk);
        check("rst.ready", 64'(b33.ready), 1);
        check("rst.valid", 64'(b33.valid), 0);
        check("rst.q", 64'(b33.quotient), 0);
        check("rst.r", 64'(b33.remainder), 0);
        check("rst.err", 64'(b33.error), 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(33'd100, 33'd7, 1'b0);
        wait_valid(0, lat, rdy_seen);
        check("u100_7.lat", 64'(lat), 34);
        check("u100_7.busy", 64'(rdy_seen), 0);
        result("u100_7", 33'd14, 33'd2, 1'b0);
        @(negedge clk);
        check("pulse.valid", 64'(b33.valid), 0);
        check("pulse.ready", 64'(b33.ready), 1);

        issue(33'h1_FFFF_FFF9, 33'd2, 1'b1);
        wait_valid(0, lat, rdy_seen);
        check("sm7_2.lat", 64'(lat), 34);
        result("sm7_2", 33'h1_FFFF_FFFD, ONES, 1'b0);
        @(negedge clk);

        issue(33'd7, 33'h1_FFFF_FFFE, 1'b1);
        wait_valid(0, lat, rdy_seen);
        result("s7_m2", 33'h1_FFFF_FFFD, 33'd1, 1'b0);
        @(negedge clk);

        issue(33'd5, 33'd0, 1'b1);
        wait_valid(0, lat, rdy_seen);
        check("dz_s.lat", 64'(lat), 1);
        result("dz_s", ONES, 33'd5, 1'b1);
        @(negedge clk);
        issue(33'd5, 33'd0, 1'b0);
        wait_valid(0, lat, rdy_seen);
        check("dz_u.lat", 64'(lat), 1);
        result("dz_u", ONES, 33'd5, 1'b1);
        @(negedge clk);
        issue(33'd20, 33'd6, 1'b0);
        wait_valid(0, lat, rdy_seen);
        result("after_dz", 33'd3, 33'd2, 1'b0);
        @(negedge clk);

        issue(33'd100, 33'd7, 1'b0);
        wait_valid(0, lat, rdy_seen);
        result("b2b_first", 33'd14, 33'd2, 1'b0);
        issue(33'd9, 33'd3, 1'b0);
        repeat (4) @(negedge clk);
        b33.start = 1'b1; b33.dividend = 33'd1; b33.divisor = 33'd1;
        @(negedge clk);
        b33.start = 1'b0;
        wait_valid(5, lat, rdy_seen);
        check("b2b.lat", 64'(lat), 34);
        check("b2b.busy", 64'(rdy_seen), 0);
        result("b2b_second", 33'd3, 33'd0, 1'b0);
        @(negedge clk);

        issue(33'd50, 33'd7, 1'b0);
        repeat (9) @(negedge clk);
        b33.kill = 1'b1; b33.start = 1'b1; b33.dividend = 33'd1; b33.divisor = 33'd1;
        @(negedge clk);
        b33.kill = 1'b0; b33.start = 1'b0;
        check("kill.ready", 64'(b33.ready), 1);
        check("kill.valid", 64'(b33.valid), 0);
        result("kill.hold", 33'd3, 33'd0, 1'b0);
        wait_valid(0, lat, rdy_seen);
        check("kill.no_valid", 64'(lat), 64'(-1));
        b33.kill = 1'b1; b33.start = 1'b1; b33.dividend = 33'd8; b33.divisor = 33'd0;
        @(negedge clk);
        b33.kill = 1'b0; b33.start = 1'b0;
        check("kill_start.valid", 64'(b33.valid), 0);
        check("kill_start.ready", 64'(b33.ready), 1);
        check("kill_start.err", 64'(b33.error), 0);
        issue(33'd20, 33'd6, 1'b0);
        wait_valid(0, lat, rdy_seen);
        check("post_kill.lat", 64'(lat), 34);
        result("post_kill", 33'd3, 33'd2, 1'b0);
        @(negedge clk);

        issue(33'd50, 33'd7, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst.ready", 64'(b33.ready), 1);
        check("midrst.valid", 64'(b33.valid), 0);
        result("midrst", 33'd0, 33'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid(0, lat, rdy_seen);
        check("midrst.no_valid", 64'(lat), 64'(-1));
        issue(33'd20, 33'd6, 1'b0);
        wait_valid(0, lat, rdy_seen);
        result("post_rst", 33'd3, 33'd2, 1'b0);
        @(negedge clk);

        b32.start = 1'b1; b32.dividend = 32'h8000_0000; b32.divisor = 32'hFFFF_FFFF; b32.is_signed = 1'b1;
        @(posedge clk);
        #1;
        b32.start = 1'b0; b32.dividend = '0; b32.divisor = '0;
        lat = -1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (b32.valid) begin
                lat = k;
                break;
            end
        end
        check("ovf.lat", 64'(lat), 33);
        check("ovf.q", 64'(b32.quotient), 64'h8000_0000);
        check("ovf.r", 64'(b32.remainder), 0);
        check("ovf.err", 64'(b32.error), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
